// File: rtl/fwd_scoreboard_pkg.sv
// Shared types for the forwarding scoreboard: in-flight entry layout and
// the bypass-select encoding.
package fwd_scoreboard_pkg;

    // Entry fields are sized for the widest supported configuration;
    // narrower register indices are zero-extended into rd.
    localparam int RD_W   = 8;
    localparam int CNT_W  = 3;
    localparam int SEL_RF = 0;

    typedef struct packed {
        logic             valid;
        logic [RD_W-1:0]  rd;
        logic [CNT_W-1:0] cnt;
    } entry_t;

    function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] c);
        return (c == '0) ? c : c - CNT_W'(1);
    endfunction

endpackage

// File: rtl/fwd_port_match.sv
// Youngest-producer search for one read port: picks the bypass entry or
// flags a hazard when the youngest producer's result is not ready yet.
module fwd_port_match
    import fwd_scoreboard_pkg::*;
#(
    parameter int REG_BITS = 5,
    parameter int DEPTH    = 3,
    parameter int LAT_BITS = 2
) (
    input  entry_t [DEPTH:1]      entries_i,
    input  logic [REG_BITS-1:0]   rs_i,
    output logic [LAT_BITS-1:0]   sel_o,
    output logic                  hazard_o
);

    logic found;

    always_comb begin
        sel_o    = LAT_BITS'(SEL_RF);
        hazard_o = 1'b0;
        found    = 1'b0;
        // Scan from youngest to oldest; the first producer decides, so an
        // older ready copy never masks a younger pending one.
        for (int k = 1; k <= DEPTH; k++) begin
            if (!found && entries_i[k].valid && entries_i[k].rd != '0 &&
                entries_i[k].rd == RD_W'(rs_i)) begin
                found = 1'b1;
                if (entries_i[k].cnt != '0) begin
                    hazard_o = 1'b1;
                end else begin
                    sel_o = LAT_BITS'(k);
                end
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Tracks in-flight register writers ahead of the consumer and produces
// per-port bypass selects plus a load-use stall.
module fwd_scoreboard
    import fwd_scoreboard_pkg::*;
#(
    parameter int REG_BITS   = 5,
    parameter int NREAD      = 2,
    parameter int DEPTH      = 3,
    localparam int LAT_BITS  = $clog2(DEPTH + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            hold,
    input  logic                            flush,
    input  logic                            issue_valid,
    input  logic                            issue_regwrite,
    input  logic [REG_BITS-1:0]             issue_rd,
    input  logic [LAT_BITS-1:0]             issue_lat,
    input  logic [NREAD-1:0][REG_BITS-1:0]  rs,
    output logic [NREAD-1:0][LAT_BITS-1:0]  sel,
    output logic                            stall,
    output logic [15:0]                     stall_cnt
);

    entry_t [DEPTH:1]     entries_q, entries_d;
    logic [15:0]          stall_cnt_q, stall_cnt_d;
    logic [NREAD-1:0]     hazard;
    logic [LAT_BITS-1:0]  lat_eff;

    for (genvar i = 0; i < NREAD; i++) begin : g_port
        fwd_port_match #(
            .REG_BITS (REG_BITS),
            .DEPTH    (DEPTH),
            .LAT_BITS (LAT_BITS)
        ) u_match (
            .entries_i (entries_q),
            .rs_i      (rs[i]),
            .sel_o     (sel[i]),
            .hazard_o  (hazard[i])
        );
    end

    assign stall     = |hazard;
    assign stall_cnt = stall_cnt_q;

    // Out-of-range latencies behave like a single-stage ALU result.
    assign lat_eff = (issue_lat == '0 || issue_lat > LAT_BITS'(DEPTH)) ?
                     LAT_BITS'(1) : issue_lat;

    always_comb begin
        entries_d   = entries_q;
        stall_cnt_d = stall_cnt_q;
        if (!hold) begin
            for (int k = DEPTH; k >= 2; k--) begin
                entries_d[k]     = entries_q[k-1];
                entries_d[k].cnt = dec_sat(entries_q[k-1].cnt);
            end
            entries_d[1] = '0;
            if (!stall && issue_valid && !flush && issue_regwrite) begin
                entries_d[1].valid = 1'b1;
                entries_d[1].rd    = RD_W'(issue_rd);
                entries_d[1].cnt   = CNT_W'(lat_eff - LAT_BITS'(1));
            end
            if (stall && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entries_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            entries_q   <= entries_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: one task per scenario, inline checks.
module tb_fwd_scoreboard;

    localparam int REG_BITS = 5;
    localparam int NREAD    = 2;
    localparam int DEPTH    = 3;
    localparam int LAT_BITS = 2;

    logic                           clk = 1'b0;
    logic                           rst;
    logic                           hold;
    logic                           flush;
    logic                           issue_valid;
    logic                           issue_regwrite;
    logic [REG_BITS-1:0]            issue_rd;
    logic [LAT_BITS-1:0]            issue_lat;
    logic [NREAD-1:0][REG_BITS-1:0] rs;
    logic [NREAD-1:0][LAT_BITS-1:0] sel;
    logic                           stall;
    logic [15:0]                    stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fwd_scoreboard #(.REG_BITS(REG_BITS), .NREAD(NREAD), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .hold           (hold),
        .flush          (flush),
        .issue_valid    (issue_valid),
        .issue_regwrite (issue_regwrite),
        .issue_rd       (issue_rd),
        .issue_lat      (issue_lat),
        .rs             (rs),
        .sel            (sel),
        .stall          (stall),
        .stall_cnt      (stall_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hold = 0; flush = 0; issue_valid = 0; issue_regwrite = 0;
        issue_rd = '0; issue_lat = '0;
    endtask

    task automatic issue(input logic [REG_BITS-1:0] rd, input logic [LAT_BITS-1:0] lat);
        issue_valid = 1; issue_regwrite = 1; issue_rd = rd; issue_lat = lat;
    endtask

    task automatic do_reset();
        idle();
        rs = '0;
        rst = 1;
        tick();
        rst = 0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (sel !== '0) begin n_fail++; $display("FAIL reset_sel got %h exp 0", sel); end
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", stall); end
        n_tests++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", stall_cnt); end
    endtask

    task automatic test_alu_fwd();
        do_reset();
        issue(5'd5, 2'd1);
        tick();
        idle(); rs[0] = 5'd5; #1;
        n_tests++; if (sel[0] !== 2'd1) begin n_fail++; $display("FAIL alu_sel1 got %0d exp 1", sel[0]); end
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL alu_stall got %b exp 0", stall); end
        tick();
        n_tests++; if (sel[0] !== 2'd2) begin n_fail++; $display("FAIL alu_sel2 got %0d exp 2", sel[0]); end
        tick();
        n_tests++; if (sel[0] !== 2'd3) begin n_fail++; $display("FAIL alu_sel3 got %0d exp 3", sel[0]); end
        tick();
        n_tests++; if (sel[0] !== 2'd0) begin n_fail++; $display("FAIL alu_retired got %0d exp 0", sel[0]); end
    endtask

    task automatic test_load_use();
        do_reset();
        issue(5'd7, 2'd2);
        tick();
        idle(); rs[1] = 5'd7;
        issue(5'd4, 2'd1);  // must be ignored while stalled
        #1;
        n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall got %b exp 1", stall); end
        n_tests++; if (sel[1] !== 2'd0) begin n_fail++; $display("FAIL lu_sel_stall got %0d exp 0", sel[1]); end
        tick();
        idle(); rs[0] = 5'd4; #1;
        n_tests++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_cnt got %0d exp 1", stall_cnt); end
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_release got %b exp 0", stall); end
        n_tests++; if (sel[1] !== 2'd2) begin n_fail++; $display("FAIL lu_sel_fwd got %0d exp 2", sel[1]); end
        n_tests++; if (sel[0] !== 2'd0) begin n_fail++; $display("FAIL lu_ignored_issue got %0d exp 0", sel[0]); end
    endtask

    task automatic test_youngest();
        do_reset();
        issue(5'd3, 2'd1); tick();
        issue(5'd3, 2'd1); tick();
        idle(); rs[0] = 5'd3; #1;
        n_tests++; if (sel[0] !== 2'd1) begin n_fail++; $display("FAIL young_sel got %0d exp 1", sel[0]); end
        do_reset();
        issue(5'd3, 2'd1); tick();
        issue(5'd3, 2'd2); tick();
        idle(); rs[0] = 5'd3; #1;
        n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL young_pending_stall got %b exp 1", stall); end
        n_tests++; if (sel[0] !== 2'd0) begin n_fail++; $display("FAIL young_pending_sel got %0d exp 0", sel[0]); end
        do_reset();
        issue(5'd0, 2'd1); tick();
        idle(); rs[0] = 5'd0; #1;
        n_tests++; if (sel[0] !== 2'd0) begin n_fail++; $display("FAIL r0_sel got %0d exp 0", sel[0]); end
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL r0_stall got %b exp 0", stall); end
    endtask

    task automatic test_hold();
        do_reset();
        issue(5'd7, 2'd2); tick();
        idle(); rs[1] = 5'd7; hold = 1; #1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL hold_stall[%0d] got %b exp 1", c, stall); end
            n_tests++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL hold_cnt[%0d] got %0d exp 0", c, stall_cnt); end
            n_tests++; if (sel[1] !== 2'd0) begin n_fail++; $display("FAIL hold_sel[%0d] got %0d exp 0", c, sel[1]); end
        end
        hold = 0;
        tick();
        n_tests++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL hold_rel_cnt got %0d exp 1", stall_cnt); end
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL hold_rel_stall got %b exp 0", stall); end
        n_tests++; if (sel[1] !== 2'd2) begin n_fail++; $display("FAIL hold_rel_sel got %0d exp 2", sel[1]); end
    endtask

    task automatic test_flush_reset();
        do_reset();
        issue(5'd9, 2'd1); flush = 1; tick();
        idle(); rs[0] = 5'd9; #1;
        n_tests++; if (sel[0] !== 2'd0) begin n_fail++; $display("FAIL flush_sel got %0d exp 0", sel[0]); end
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall got %b exp 0", stall); end
        issue(5'd9, 2'd3); tick();
        idle(); #1;
        n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lat3_stall got %b exp 1", stall); end
        tick();
        n_tests++; if (stall_cnt !== 16'd1 || stall !== 1'b1) begin
            n_fail++; $display("FAIL lat3_mid got cnt=%0d stall=%b exp cnt=1 stall=1", stall_cnt, stall); end
        rst = 1; hold = 1; tick(); rst = 0; hold = 0; #1;
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stall got %b exp 0", stall); end
        n_tests++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_mid_cnt got %0d exp 0", stall_cnt); end
    endtask

    task automatic test_lat_clamp();
        do_reset();
        issue(5'd6, 2'd0); tick();
        idle(); rs[1] = 5'd6; #1;
        n_tests++; if (sel[1] !== 2'd1 || stall !== 1'b0) begin
            n_fail++; $display("FAIL lat0_clamp got sel=%0d stall=%b exp sel=1 stall=0", sel[1], stall); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        issue(5'd1, 2'd1); tick();
        issue(5'd2, 2'd1); tick();
        idle(); rs[0] = 5'd1; rs[1] = 5'd2; #1;
        n_tests++; if (sel[0] !== 2'd2) begin n_fail++; $display("FAIL b2b_sel0 got %0d exp 2", sel[0]); end
        n_tests++; if (sel[1] !== 2'd1) begin n_fail++; $display("FAIL b2b_sel1 got %0d exp 1", sel[1]); end
        issue(5'd1, 2'd1); issue_regwrite = 0; tick();
        idle(); #1;
        n_tests++; if (sel[0] !== 2'd3 || sel[1] !== 2'd2) begin
            n_fail++; $display("FAIL nowrite got sel0=%0d sel1=%0d exp 3/2", sel[0], sel[1]); end
    endtask

    initial begin
        rst = 1; rs = '0; idle();
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_youngest();
        test_hold();
        test_flush_reset();
        test_lat_clamp();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fwd_scoreboard.md
FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 SHALL have parameter REG_BITS, default 5, register-index width.
REQ-002 SHALL have parameter NREAD, default 2, number of source-operand read ports.
REQ-003 SHALL have parameter DEPTH, default 3, number of tracked in-flight stages (2..7).
REQ-004 SHALL have parameter LAT_BITS = $clog2(DEPTH+1), latency field width, derived and not overridable.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-007 SHALL have port hold, input, 1, global pipeline freeze (e.g. memory wait).
REQ-008 SHALL have port flush, input, 1, kill the instruction currently issuing.
REQ-009 SHALL have port issue_valid, input, 1, consumer instruction advances into EX this cycle.
REQ-010 SHALL have port issue_regwrite, input, 1, issuing instruction writes a register.
REQ-011 SHALL have port issue_rd, input, REG_BITS, destination of issuing instruction.
REQ-012 SHALL have port issue_lat, input, LAT_BITS, result latency in stages (1 = ALU, 2 = load), range 1..DEPTH.
REQ-013 SHALL have port rs, input, NREAD x REG_BITS, source registers of the consumer.
REQ-014 SHALL have port sel, output, NREAD x LAT_BITS, per-port bypass select; 0 = register file, k = entry k.
REQ-015 SHALL have port stall, output, 1, load-use/latency hazard; upstream holds the consumer.
REQ-016 SHALL have port stall_cnt, output, 16, saturating count of stall cycles.

Function
REQ-017 SHALL keep DEPTH entries {valid, rd, cnt}; entry 1 is the instruction one stage ahead of the consumer, entry k is k stages ahead.
REQ-018 Advance (hold=0): entry k+1 <= entry k for k=1..DEPTH-1; entry DEPTH retires; each shifted cnt decrements, saturating at 0.
REQ-019 On advance with stall=0, issue_valid=1, flush=0, issue_regwrite=1: entry 1 <= {1, issue_rd, issue_lat-1}; otherwise entry 1 <= bubble (valid=0).
REQ-020 An entry is a producer for port i when valid=1, rd==rs[i], rd!=0.
REQ-021 sel[i] SHALL be the smallest k whose entry produces rs[i]; youngest producer wins; 0 when none.
REQ-022 If that youngest producer has cnt!=0, sel[i] SHALL be 0 and stall SHALL be 1; older ready producers SHALL NOT be used.
REQ-023 stall SHALL be the OR over all ports of REQ-022; sel and stall are combinational from entries and rs.
REQ-024 rs[i]==0 SHALL give sel[i]=0 and no stall contribution.
REQ-025 stall=1 with hold=0: bubble into entry 1, remaining entries advance (REQ-018); issue inputs ignored.
REQ-026 hold=1: all entries, stall_cnt frozen; sel/stall still evaluated; hold dominates stall and flush.
REQ-027 stall_cnt increments on each cycle with stall=1 and hold=0; saturates at 16'hFFFF.
REQ-028 issue_lat=0 or >DEPTH SHALL be treated as 1.

Reset
REQ-029 rst=1 at a clock edge SHALL clear all valid, rd, cnt and stall_cnt to 0, overriding hold, flush and issue, including mid-stall.
REQ-030 After reset: sel all 0, stall=0 until a new producer is issued.

Structure
REQ-031 Shared package SHALL hold the entry struct {valid, rd, cnt} and the sel encoding constant SEL_RF=0.
REQ-032 One sub-module fwd_port_match (one per read port, generate loop) SHALL perform the youngest-match search returning sel and hazard.

Verification
REQ-033 Issue rd=5 lat=1, next cycle rs[0]=5 -> sel[0]=1, stall=0; following cycle -> sel[0]=2.
REQ-034 Issue rd=7 lat=2, next cycle rs[1]=7 -> stall=1 one cycle, stall_cnt=1; then sel[1]=2, stall=0.
REQ-035 Entries 1 and 2 both rd=3 ready, rs[0]=3 -> sel[0]=1; rs[0]=0 with an rd=0 issue -> sel[0]=0, no stall.
REQ-036 Load-use stall active, hold=1 three cycles -> stall stays 1, entries and stall_cnt unchanged; release -> resumes per REQ-034.
REQ-037 Issue rd=9 with flush=1 -> rs=9 next cycle gives sel=0; rst asserted mid-stall -> next cycle stall=0, stall_cnt=0.
